// File: rtl/acc_pkg.sv
// Shared types for the acc segment feeder: segment record, FSM encoding, queue depth default.
package acc_pkg;

  localparam int DATA_W         = 32;
  localparam int DEPTH_LOG2_DEF = 4;

  typedef struct packed {
    logic [DATA_W-1:0] dt;
    logic [DATA_W-1:0] steps;
  } seg_t;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_UNDERRUN = 2'd2;
  localparam logic [1:0] ST_STOPPING = 2'd3;

  // A segment with a zero interval or zero step count would stall acc_step_gen.
  function automatic logic seg_ok(input seg_t s);
    return (s.dt != '0) && (s.steps != '0);
  endfunction

endpackage

// File: rtl/acc_seg_feeder_if.sv
// Host write bus plus acc_step_gen control/status bundle for the segment feeder.
interface acc_seg_feeder_if
  import acc_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
);
  logic              wr_stb;
  logic [DATA_W-1:0] wr_dt;
  logic [DATA_W-1:0] wr_steps;
  logic              start;
  logic              stop;
  logic              sg_done;
  logic              sg_abort;
  logic              sg_step_stb;
  logic [DATA_W-1:0] dt_val;
  logic [DATA_W-1:0] steps_val;
  logic              load;
  logic              set_dt_limit;
  logic              set_steps_limit;
  logic              reset_dt;
  logic              reset_steps;
  logic              full;
  logic [DEPTH_LOG2:0] level;
  logic              busy;
  logic              underrun;
  logic              aborted;
  logic              wr_err;
  logic [15:0]       seg_count;

  modport master (
    output wr_stb, wr_dt, wr_steps, start, stop, sg_done, sg_abort, sg_step_stb,
    input  dt_val, steps_val, load, set_dt_limit, set_steps_limit, reset_dt, reset_steps,
    input  full, level, busy, underrun, aborted, wr_err, seg_count
  );

  modport slave (
    input  wr_stb, wr_dt, wr_steps, start, stop, sg_done, sg_abort, sg_step_stb,
    output dt_val, steps_val, load, set_dt_limit, set_steps_limit, reset_dt, reset_steps,
    output full, level, busy, underrun, aborted, wr_err, seg_count
  );
endinterface

// File: rtl/seg_fifo.sv
// Single-clock show-ahead FIFO of segment records with synchronous flush.
module seg_fifo
  import acc_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  seg_t                din,
  output seg_t                dout,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] level
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  seg_t                  mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full  = level[DEPTH_LOG2];
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr];

  // A pop frees the slot the same cycle, so push-while-full is legal alongside it.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/acc_seg_feeder.sv
// Segment sequencer: queues host segments and chains them into acc_step_gen via load strobes.
module acc_seg_feeder
  import acc_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic           clk,
  input  logic           reset,
  acc_seg_feeder_if.slave bus
);
  seg_t                fifo_din;
  seg_t                fifo_dout;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_flush;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DEPTH_LOG2:0] fifo_level;

  logic [1:0]  state;
  logic [1:0]  state_n;
  logic        ld;
  logic        ld_zero;
  logic        ld_rdt;
  logic        do_clear;
  logic        set_under;
  logic        set_abort;
  logic        cnt_inc;
  logic        wr_rej;
  logic        has_seg;

  logic [DATA_W-1:0] dt_val;
  logic [DATA_W-1:0] steps_val;
  logic        load;
  logic        set_limits;
  logic        reset_dt;
  logic        busy;
  logic        underrun;
  logic        aborted;
  logic        wr_err;
  logic [15:0] seg_count;
  logic        unused_step_stb;

  assign unused_step_stb = bus.sg_step_stb;

  assign fifo_din.dt    = bus.wr_dt;
  assign fifo_din.steps = bus.wr_steps;
  assign has_seg        = !fifo_empty;

  // Writes coinciding with stop are swallowed by the flush without flagging an error.
  assign fifo_push = bus.wr_stb && seg_ok(fifo_din);
  assign wr_rej    = bus.wr_stb && !bus.stop &&
                     (!seg_ok(fifo_din) || (fifo_full && !fifo_pop));

  seg_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_n    = state;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    ld         = 1'b0;
    ld_zero    = 1'b0;
    ld_rdt     = 1'b0;
    do_clear   = 1'b0;
    set_under  = 1'b0;
    set_abort  = 1'b0;
    cnt_inc    = 1'b0;
    if (bus.stop) begin
      fifo_flush = 1'b1;
      ld         = 1'b1;
      ld_zero    = 1'b1;
      ld_rdt     = 1'b1;
      state_n    = ST_STOPPING;
    end else begin
      do_clear = bus.start;
      case (state)
        ST_IDLE: begin
          if (bus.start && has_seg) begin
            fifo_pop = 1'b1;
            ld       = 1'b1;
            ld_rdt   = 1'b1;
            state_n  = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.sg_abort) begin
            set_abort = 1'b1;
            state_n   = ST_IDLE;
          end else if (bus.sg_done) begin
            cnt_inc = 1'b1;
            if (has_seg) begin
              fifo_pop = 1'b1;
              ld       = 1'b1;
            end else begin
              set_under = 1'b1;
              state_n   = ST_UNDERRUN;
            end
          end
        end
        ST_UNDERRUN: begin
          if (bus.sg_abort) begin
            set_abort = 1'b1;
            state_n   = ST_IDLE;
          end else if (has_seg) begin
            fifo_pop = 1'b1;
            ld       = 1'b1;
            state_n  = ST_RUN;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Register stage: every status and strobe to acc_step_gen leaves from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      load       <= 1'b0;
      set_limits <= 1'b0;
      reset_dt   <= 1'b0;
      dt_val     <= '0;
      steps_val  <= '0;
      underrun   <= 1'b0;
      aborted    <= 1'b0;
      wr_err     <= 1'b0;
      seg_count  <= '0;
    end else begin
      state      <= state_n;
      busy       <= (state_n != ST_IDLE);
      load       <= ld;
      set_limits <= ld;
      reset_dt   <= ld_rdt;
      if (ld) begin
        dt_val    <= ld_zero ? '0 : fifo_dout.dt;
        steps_val <= ld_zero ? '0 : fifo_dout.steps;
      end
      underrun  <= do_clear ? 1'b0 : (underrun | set_under);
      aborted   <= do_clear ? 1'b0 : (aborted | set_abort);
      wr_err    <= (wr_err & !do_clear) | wr_rej;
      seg_count <= do_clear ? 16'd0 : (seg_count + {15'd0, cnt_inc});
    end
  end

  assign bus.dt_val          = dt_val;
  assign bus.steps_val       = steps_val;
  assign bus.load            = load;
  assign bus.set_dt_limit    = set_limits;
  assign bus.set_steps_limit = set_limits;
  assign bus.reset_dt        = reset_dt;
  assign bus.reset_steps     = set_limits;
  assign bus.full            = fifo_full;
  assign bus.level           = fifo_level;
  assign bus.busy            = busy;
  assign bus.underrun        = underrun;
  assign bus.aborted         = aborted;
  assign bus.wr_err          = wr_err;
  assign bus.seg_count       = seg_count;

endmodule

// File: tb/tb_acc_seg_feeder.sv
// Scoreboard bench for acc_seg_feeder: expected loads queued at stimulus time, checked on each load strobe.
module tb_acc_seg_feeder;
  import acc_pkg::*;

  localparam int DL2 = 4;

  typedef struct {
    logic [31:0] dt;
    logic [31:0] steps;
    logic        rdt;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_tests;
  int   n_fail;
  exp_t sb [$];

  acc_seg_feeder_if #(.DEPTH_LOG2(DL2)) bus ();

  acc_seg_feeder #(.DEPTH_LOG2(DL2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every load strobe must match the oldest queued expectation, including its cycle.
  always @(negedge clk) begin
    if (!reset && bus.load === 1'b1) begin
      chk("load_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("load_cycle", 64'(cyc), 64'(e.cyc));
        chk("load_data", {bus.dt_val, bus.steps_val}, {e.dt, e.steps});
        chk("load_ctrl", {61'd0, bus.set_dt_limit, bus.set_steps_limit, bus.reset_steps}, 64'd7);
        chk("load_reset_dt", 64'(bus.reset_dt), 64'(e.rdt));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.sg_step_stb = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic exp_load(input logic [31:0] dt, input logic [31:0] steps, input logic rdt,
                          input int lat = 1);
    exp_t e;
    e.dt = dt; e.steps = steps; e.rdt = rdt; e.cyc = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic write(input logic [31:0] dt, input logic [31:0] steps);
    bus.wr_stb = 1'b1; bus.wr_dt = dt; bus.wr_steps = steps;
    tick(1);
    bus.wr_stb = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; tick(1); bus.start = 1'b0;
  endtask

  task automatic pulse_done();
    bus.sg_done = 1'b1; tick(1); bus.sg_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, {37'd0, bus.load, bus.set_dt_limit, bus.set_steps_limit, bus.reset_dt,
        bus.reset_steps, bus.full, bus.busy, bus.underrun, bus.aborted, bus.wr_err,
        bus.level, bus.seg_count}, 64'd0);
    chk({tag, "_data"}, {bus.dt_val, bus.steps_val}, 64'd0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    reset = 1'b1;
    bus.wr_stb = 1'b0; bus.wr_dt = '0; bus.wr_steps = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.sg_done = 1'b0;
    bus.sg_abort = 1'b0; bus.sg_step_stb = 1'b0;
    tick(2);
    reset = 1'b0;
    check_all_zero("reset");

    // First load after start
    write(32'd10, 32'd3);
    chk("t1_level_pre", 64'(bus.level), 64'd1);
    exp_load(32'd10, 32'd3, 1'b1);
    pulse_start();
    chk("t1_busy", 64'(bus.busy), 64'd1);
    chk("t1_level_post", 64'(bus.level), 64'd0);
    tick(2);

    // Chaining on sg_done
    do_reset();
    write(32'd10, 32'd3);
    write(32'd20, 32'd2);
    exp_load(32'd10, 32'd3, 1'b1);
    pulse_start();
    tick(2);
    exp_load(32'd20, 32'd2, 1'b0);
    pulse_done();
    chk("t2_seg_count", 64'(bus.seg_count), 64'd1);
    chk("t2_level", 64'(bus.level), 64'd0);
    tick(2);

    // Underrun, then late recovery
    pulse_done();
    chk("t3_underrun", 64'(bus.underrun), 64'd1);
    chk("t3_busy_ur", 64'(bus.busy), 64'd1);
    chk("t3_seg_count", 64'(bus.seg_count), 64'd2);
    exp_load(32'd5, 32'd1, 1'b0, 2);
    write(32'd5, 32'd1);
    tick(2);
    chk("t3_underrun_sticky", 64'(bus.underrun), 64'd1);
    chk("t3_busy_run", 64'(bus.busy), 64'd1);

    // Underrun followed by abort
    pulse_done();
    bus.sg_abort = 1'b1; tick(1); bus.sg_abort = 1'b0;
    chk("t3_aborted", 64'(bus.aborted), 64'd1);
    chk("t3_busy_abort", 64'(bus.busy), 64'd0);
    pulse_start();
    chk("t3_clear_flags", {61'd0, bus.underrun, bus.aborted, bus.busy}, 64'd0);
    chk("t3_clear_count", 64'(bus.seg_count), 64'd0);
    tick(3);

    // Full queue, overflow, push+pop at full, stop flush
    do_reset();
    for (int i = 1; i <= 16; i++) write(32'(i), 32'(i));
    chk("t4_level16", 64'(bus.level), 64'd16);
    chk("t4_full", 64'(bus.full), 64'd1);
    write(32'd99, 32'd99);
    chk("t4_overflow_err", 64'(bus.wr_err), 64'd1);
    chk("t4_overflow_level", 64'(bus.level), 64'd16);
    exp_load(32'd1, 32'd1, 1'b1);
    bus.start = 1'b1; bus.wr_stb = 1'b1; bus.wr_dt = 32'd100; bus.wr_steps = 32'd100;
    tick(1);
    bus.start = 1'b0; bus.wr_stb = 1'b0;
    chk("t4_pushpop_level", 64'(bus.level), 64'd16);
    chk("t4_pushpop_err", 64'(bus.wr_err), 64'd0);
    exp_load(32'd0, 32'd0, 1'b1);
    bus.stop = 1'b1; tick(1); bus.stop = 1'b0;
    chk("t4_flush_level", 64'(bus.level), 64'd0);
    chk("t4_stopping_busy", 64'(bus.busy), 64'd1);
    tick(1);
    chk("t4_idle_busy", 64'(bus.busy), 64'd0);

    // Zero-field writes are rejected
    do_reset();
    for (int i = 1; i <= 3; i++) write(32'(i * 7), 32'(i));
    write(32'd7, 32'd0);
    chk("t4_steps0_err", 64'(bus.wr_err), 64'd1);
    chk("t4_steps0_level", 64'(bus.level), 64'd3);
    do_reset();
    write(32'd0, 32'd5);
    chk("t4_dt0_err", 64'(bus.wr_err), 64'd1);
    chk("t4_dt0_level", 64'(bus.level), 64'd0);

    // Stop colliding with sg_done
    do_reset();
    write(32'd10, 32'd3);
    write(32'd20, 32'd2);
    write(32'd30, 32'd4);
    exp_load(32'd10, 32'd3, 1'b1);
    pulse_start();
    tick(2);
    exp_load(32'd0, 32'd0, 1'b1);
    bus.stop = 1'b1; bus.sg_done = 1'b1;
    tick(1);
    bus.stop = 1'b0; bus.sg_done = 1'b0;
    chk("t5_level", 64'(bus.level), 64'd0);
    chk("t5_busy1", 64'(bus.busy), 64'd1);
    tick(1);
    chk("t5_busy2", 64'(bus.busy), 64'd0);
    tick(3);

    // Reset in RUN with a partly filled queue
    do_reset();
    for (int i = 1; i <= 6; i++) write(32'(i + 40), 32'(i));
    exp_load(32'd41, 32'd1, 1'b1);
    pulse_start();
    chk("t6_level5", 64'(bus.level), 64'd5);
    tick(1);
    reset = 1'b1;
    tick(1);
    check_all_zero("t6_reset");
    reset = 1'b0;
    pulse_start();
    tick(3);
    chk("t6_no_load_busy", 64'(bus.busy), 64'd0);
    chk("t6_no_load_level", 64'(bus.level), 64'd0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
